// File: rtl/branch_predict_unit.sv
// RV32 branch resolution in EX, plus a PC-indexed saturating-counter direction predictor
// and saturating branch/mispredict statistics.
module branch_predict_unit #(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned CTR_BITS  = 2,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [31:0]          IF_PC,
   output logic                 PREDICT_TAKEN,
   input  logic                 EX_VALID,
   input  logic [31:0]          EX_PC,
   input  logic [2:0]           EX_SIGNAL,
   input  logic                 EQ,
   input  logic                 LT,
   input  logic                 LTU,
   input  logic                 EX_PREDICTED,
   output logic                 BRANCH_TAKEN,
   output logic                 MISPREDICT,
   input  logic                 CLR_STATS,
   output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
   output logic [CNT_WIDTH-1:0] MISPREDICT_COUNT
);

   localparam int unsigned IDX_BITS = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0]  CtrMax = '1;
   localparam logic [CTR_BITS-1:0]  WeakNt = CtrMax >> 1;
   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   logic [CTR_BITS-1:0]  table_q [ENTRIES];
   logic [CTR_BITS-1:0]  cur_ctr, upd_ctr;
   logic [IDX_BITS-1:0]  if_idx, ex_idx;
   logic                 is_br, cond;
   logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   logic                 unused_pc;

   assign if_idx = IF_PC[IDX_BITS+1:2];
   assign ex_idx = EX_PC[IDX_BITS+1:2];
   assign unused_pc = ^{IF_PC[31:IDX_BITS+2], IF_PC[1:0], EX_PC[31:IDX_BITS+2], EX_PC[1:0]};

   // Written as a range test so an unknown EX_SIGNAL propagates to is_br and is caught below.
   assign is_br = EX_VALID && (EX_SIGNAL inside {[3'd1:3'd6]});

   always_comb begin
      cond = 1'b0;
      case (EX_SIGNAL)
         3'd1:    cond = EQ;
         3'd2:    cond = !EQ;
         3'd3:    cond = LT;
         3'd4:    cond = !LT;
         3'd5:    cond = LTU;
         3'd6:    cond = !LTU;
         default: cond = 1'b0;
      endcase
   end

   assign BRANCH_TAKEN  = is_br && cond;
   assign MISPREDICT    = is_br && (cond != EX_PREDICTED);
   assign PREDICT_TAKEN = table_q[if_idx][CTR_BITS-1];

   assign cur_ctr = table_q[ex_idx];

   always_comb begin
      upd_ctr = cur_ctr;
      if (cond) begin
         if (cur_ctr != CtrMax) upd_ctr = cur_ctr + CTR_BITS'(1);
      end else begin
         if (cur_ctr != '0) upd_ctr = cur_ctr - CTR_BITS'(1);
      end
   end

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (CLR_STATS) begin
         br_cnt_d  = '0;
         mis_cnt_d = '0;
      end else if (is_br) begin
         if (br_cnt_q != CntMax) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
         if (MISPREDICT && (mis_cnt_q != CntMax)) mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= WeakNt;
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (is_br) table_q[ex_idx] <= upd_ctr;
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign BRANCH_COUNT     = br_cnt_q;
   assign MISPREDICT_COUNT = mis_cnt_q;

   a_is_br_known: assert property (@(posedge CLK) disable iff (RESET) !$isunknown(is_br));

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Successor to the combinational branch-condition decoder. Resolves RV32 conditional branches in EX from comparator flags (EQ, LT, LTU).
- Adds a parametrised direction predictor: a table of saturating counters indexed by PC, read in IF and trained in EX.
- Flags mispredictions for pipeline flush and keeps saturating branch/mispredict statistics counters.
- Sits between the ALU comparator outputs, the IF next-PC mux and the hazard/flush unit.

Parameters:
ENTRIES, 16, predictor table depth; power of two, >=2; IDX_BITS = log2(ENTRIES)
CTR_BITS, 2, width of each saturating direction counter; >=1
CNT_WIDTH, 32, width of each statistics counter

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
IF_PC  input  32  fetch PC for the prediction lookup
PREDICT_TAKEN  output  1  combinational prediction for IF_PC
EX_VALID  input  1  EX-stage instruction is valid (not bubble/flushed)
EX_PC  input  32  PC of the EX-stage instruction
EX_SIGNAL  input  3  branch type: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 none
EQ  input  1  rs1 == rs2
LT  input  1  rs1 < rs2, signed
LTU  input  1  rs1 < rs2, unsigned
EX_PREDICTED  input  1  prediction made for this instruction in IF, carried down the pipeline
BRANCH_TAKEN  output  1  resolved direction, combinational
MISPREDICT  output  1  resolved direction differs from EX_PREDICTED, combinational
CLR_STATS  input  1  synchronous clear of statistics counters
BRANCH_COUNT  output  CNT_WIDTH  resolved branches, saturating
MISPREDICT_COUNT  output  CNT_WIDTH  mispredictions, saturating

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous and active-high.
- Branch qualification: is_br = EX_VALID && EX_SIGNAL in 1..6. Codes 0 and 7 are not branches.
- Condition: cond = EQ, !EQ, LT, !LT, LTU, !LTU for codes 1..6 respectively.
  - BRANCH_TAKEN = is_br && cond.
  - MISPREDICT = is_br && (cond != EX_PREDICTED).
  - Both are 0 whenever is_br = 0. No added delay; both settle in the same cycle as their inputs.
- Index: idx(pc) = pc[IDX_BITS+1:2]. pc[1:0] is ignored.
  - No tags, so aliasing PCs share an entry; this is intended.
- Counter states:
  - Reset value is WEAK_NT = 2^(CTR_BITS-1)-1 (01 for CTR_BITS=2; 0 for CTR_BITS=1).
  - PREDICT_TAKEN = table[idx(IF_PC)][CTR_BITS-1]. Pure combinational read, no latency.
  - For CTR_BITS=2 the states are SNT 00, WNT 01, WT 10, ST 11.
- Training: on a rising CLK edge with is_br=1, entry idx(EX_PC) is updated.
  - cond=1: increment, saturating at all-ones.
  - cond=0: decrement, saturating at 0.
  - No update when is_br=0.
- Simultaneous lookup/update of the same index: read-before-write. PREDICT_TAKEN reflects the pre-edge value; the new value is visible after the edge.
- Statistics: on a rising edge with is_br=1, BRANCH_COUNT += 1. If MISPREDICT=1, MISPREDICT_COUNT += 1 as well.
  - Each counter saturates at 2^CNT_WIDTH-1 and never wraps.
  - CLR_STATS=1 zeroes both counters at the edge and takes priority over a same-cycle increment.
  - CLR_STATS does not touch the predictor table.
- Reset, including mid-operation:
  - All table entries go to WEAK_NT and both counters go to 0 immediately.
  - PREDICT_TAKEN therefore reads 0 with no clock edge.
  - BRANCH_TAKEN and MISPREDICT stay purely input-driven.
  - The first training edge after RESET deasserts behaves normally.
- Unknown or X EX_SIGNAL must not corrupt the table. Verification treats X on is_br at an edge as an assertion failure.

Test Plan:
1. Reset, IF_PC=0x40 -> PREDICT_TAKEN=0, BRANCH_COUNT=0, MISPREDICT_COUNT=0. Every index reads 0 (sweep IF_PC 0x00..0x3C).
2. EX_VALID=1, EX_SIGNAL=1, EQ=1, EX_PC=0x40, EX_PREDICTED=0 -> same cycle BRANCH_TAKEN=1, MISPREDICT=1. After the edge: IF_PC=0x00 (alias, idx 0) gives PREDICT_TAKEN=1; BRANCH_COUNT=1, MISPREDICT_COUNT=1.
3. Three BGEU (code 6, LTU=0, EX_PREDICTED=1) at EX_PC=0x84 -> entry 1 saturates at 11. Then one BLTU with LTU=0 (not taken) -> entry 10, PREDICT_TAKEN still 1, MISPREDICT=1 on that cycle.
4. IF_PC=EX_PC=0x88 with a taken BNE from WNT -> PREDICT_TAKEN=0 before the edge, 1 after.
5. EX_VALID=1 with EX_SIGNAL=0, then 7; separately EX_VALID=0 with EX_SIGNAL=1, EQ=1 -> BRANCH_TAKEN=0, MISPREDICT=0; table and counters unchanged.
6. CNT_WIDTH=4, 17 mispredicted branches -> both counts hold at 15. Next, CLR_STATS=1 together with a branch -> both 0. Then assert RESET between edges after training idx 2 to ST -> PREDICT_TAKEN for 0x08 drops to 0 immediately.
